// File: rtl/frame_writer.sv
// Write-side engine for the dual-port frame buffer: accepts fill-rect and clear-screen
// commands, clips them to the screen and streams one raster-order pixel write per clock.
module frame_writer #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [9:0]         cmd_x,
  input  logic [9:0]         cmd_y,
  input  logic [9:0]         cmd_w,
  input  logic [9:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  pixel_count,
  output logic [ADDR_W-1:0]  fb_wraddress,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_wren,
  output logic [1:0]         dbg_state
);

  // Handshake: a command transfers on the rising edge where cmd_valid and cmd_ready are
  // both 1 while idle. cmd_ready is registered and drops for the whole command; any
  // cmd_valid seen while it is low is dropped, never queued.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [10:0]       H_END  = 11'(H_RES);
  localparam logic [10:0]       V_END  = 11'(V_RES);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

  state_t state_q, state_d;

  logic               rsvd_q;
  logic [9:0]         x_q, y_q, w_q, h_q;
  logic [COLOR_W-1:0] color_q;

  logic [10:0]        x_end_q, y_end_q;
  logic [10:0]        cx_q, cy_q;
  logic [ADDR_W-1:0]  row_base_q;
  logic [ADDR_W-1:0]  count_q;

  logic               cmd_ready_q, busy_q, done_q, fb_wren_q;
  logic [ADDR_W-1:0]  pixel_count_q, fb_wraddress_q;
  logic [COLOR_W-1:0] fb_data_q;

  logic               accept;
  logic [10:0]        x_sum, y_sum, x_end_d, y_end_d;
  logic               empty_cmd;
  logic               last_col, last_row;
  logic [ADDR_W-1:0]  y_ext, row_base_init;

  assign accept = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;

  // 11-bit sums so x+w and y+h cannot wrap before the clip compare.
  assign x_sum   = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum   = {1'b0, y_q} + {1'b0, h_q};
  assign x_end_d = (x_sum > H_END) ? H_END : x_sum;
  assign y_end_d = (y_sum > V_END) ? V_END : y_sum;

  assign empty_cmd = rsvd_q || (w_q == 10'd0) || (h_q == 10'd0) ||
                     ({1'b0, x_q} >= H_END) || ({1'b0, y_q} >= V_END);

  assign last_col = (cx_q == (x_end_q - 11'd1));
  assign last_row = (cy_q == (y_end_q - 11'd1));

  assign y_ext = ADDR_W'(y_q);

  // y*640 decomposes into y*512 + y*128; other widths fall back to a constant multiply.
  if (H_RES == 640) begin : g_row_shift
    assign row_base_init = (y_ext << 9) + (y_ext << 7);
  end else begin : g_row_mul
    assign row_base_init = y_ext * H_STEP;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SETUP;
      S_SETUP: state_d = empty_cmd ? S_DONE : S_DRAW;
      S_DRAW:  if (last_col && last_row) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Clear-screen is rewritten into a full-screen fill at accept time.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsvd_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
    end else if (accept) begin
      rsvd_q  <= cmd_op[1];
      color_q <= cmd_color;
      if (cmd_op == 2'b01) begin
        x_q <= '0;
        y_q <= '0;
        w_q <= 10'(H_RES);
        h_q <= 10'(V_RES);
      end else begin
        x_q <= cmd_x;
        y_q <= cmd_y;
        w_q <= cmd_w;
        h_q <= cmd_h;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x_end_q    <= '0;
      y_end_q    <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      row_base_q <= '0;
      count_q    <= '0;
    end else begin
      case (state_q)
        S_SETUP: begin
          x_end_q    <= x_end_d;
          y_end_q    <= y_end_d;
          cx_q       <= {1'b0, x_q};
          cy_q       <= {1'b0, y_q};
          row_base_q <= row_base_init;
          count_q    <= '0;
        end
        S_DRAW: begin
          count_q <= count_q + 1'b1;
          if (last_col) begin
            cx_q       <= {1'b0, x_q};
            cy_q       <= cy_q + 11'd1;
            row_base_q <= row_base_q + H_STEP;
          end else begin
            cx_q <= cx_q + 11'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs lag the state by one register; ready returns the cycle after done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cmd_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pixel_count_q  <= '0;
      fb_wraddress_q <= '0;
      fb_data_q      <= '0;
      fb_wren_q      <= 1'b0;
    end else begin
      cmd_ready_q <= (state_q == S_IDLE) && (state_d == S_IDLE);
      busy_q      <= !((state_q == S_IDLE) && (state_d == S_IDLE));
      done_q      <= (state_q == S_DONE);
      fb_wren_q   <= (state_q == S_DRAW);
      if (state_q == S_DONE) pixel_count_q <= count_q;
      if (state_q == S_DRAW) begin
        fb_wraddress_q <= row_base_q + ADDR_W'(cx_q);
        fb_data_q      <= color_q;
      end
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pixel_count  = pixel_count_q;
  assign fb_wraddress = fb_wraddress_q;
  assign fb_data      = fb_data_q;
  assign fb_wren      = fb_wren_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: a full-size instance for fill/clip/empty/reset cases and
// a reduced-resolution instance so a whole clear-screen stays short.
module tb_frame_writer;

  logic        Clk;
  logic        Reset;
  int          cyc;
  int          n_cmp;
  int          n_fail;

  // full-size instance
  logic        cmd_valid, cmd_ready, busy, done, fb_wren;
  logic [1:0]  cmd_op, dbg_state;
  logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [7:0]  cmd_color, fb_data;
  logic [18:0] pixel_count, fb_wraddress;

  // 32x24 instance
  logic        s_cmd_valid, s_cmd_ready, s_busy, s_done, s_fb_wren;
  logic [1:0]  s_cmd_op, s_dbg_state;
  logic [9:0]  s_cmd_x, s_cmd_y, s_cmd_w, s_cmd_h;
  logic [7:0]  s_cmd_color, s_fb_data;
  logic [18:0] s_pixel_count, s_fb_wraddress;

  logic [18:0] m_addr_q[$];
  logic [7:0]  m_data_q[$];
  int          m_cyc_q[$];
  int          m_done_q[$];
  logic [18:0] s_addr_q[$];
  logic [7:0]  s_data_q[$];
  int          s_cyc_q[$];
  int          s_done_q[$];
  logic [18:0] exp_q[$];

  frame_writer dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .busy(busy), .done(done), .pixel_count(pixel_count),
    .fb_wraddress(fb_wraddress), .fb_data(fb_data), .fb_wren(fb_wren),
    .dbg_state(dbg_state)
  );

  frame_writer #(.H_RES(32), .V_RES(24)) dut_s (
    .Clk(Clk), .Reset(Reset), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(s_cmd_op), .cmd_x(s_cmd_x), .cmd_y(s_cmd_y), .cmd_w(s_cmd_w), .cmd_h(s_cmd_h),
    .cmd_color(s_cmd_color), .busy(s_busy), .done(s_done), .pixel_count(s_pixel_count),
    .fb_wraddress(s_fb_wraddress), .fb_data(s_fb_data), .fb_wren(s_fb_wren),
    .dbg_state(s_dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog expired");
  end

  // write/done monitor, sampled on the falling edge
  always @(negedge Clk) begin
    if (fb_wren === 1'b1) begin
      m_addr_q.push_back(fb_wraddress);
      m_data_q.push_back(fb_data);
      m_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) m_done_q.push_back(cyc);
    if (s_fb_wren === 1'b1) begin
      s_addr_q.push_back(s_fb_wraddress);
      s_data_q.push_back(s_fb_data);
      s_cyc_q.push_back(cyc);
    end
    if (s_done === 1'b1) s_done_q.push_back(cyc);
  end

  // driver tasks: called right after a falling edge
  task automatic send_cmd(input bit sel, input logic [1:0] op, input logic [9:0] x,
                          input logic [9:0] y, input logic [9:0] w, input logic [9:0] h,
                          input logic [7:0] color, output int acc_edge);
    if (!sel) begin
      cmd_op = op; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = color;
      cmd_valid = 1'b1;
    end else begin
      s_cmd_op = op; s_cmd_x = x; s_cmd_y = y; s_cmd_w = w; s_cmd_h = h; s_cmd_color = color;
      s_cmd_valid = 1'b1;
    end
    acc_edge = cyc + 1;
    @(negedge Clk);
    cmd_valid = 1'b0;
    s_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, output int done_edge, output bit ok);
    ok = 1'b0;
    done_edge = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      if ((sel ? s_done : done) === 1'b1) begin
        done_edge = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_mon();
    m_addr_q.delete(); m_data_q.delete(); m_cyc_q.delete(); m_done_q.delete();
    s_addr_q.delete(); s_data_q.delete(); s_cyc_q.delete(); s_done_q.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (fb_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", fb_wren); end
    n_cmp++; if (fb_wraddress !== 19'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", fb_wraddress); end
    n_cmp++; if (pixel_count !== 19'd0) begin n_fail++; $display("FAIL reset_pixel_count got %0d want 0", pixel_count); end
    n_cmp++; if (fb_data !== 8'd0) begin n_fail++; $display("FAIL reset_data got %0h want 0", fb_data); end
    n_cmp++; if (s_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_small_ready got %b want 1", s_cmd_ready); end
  endtask

  task automatic test_fill_basic();
    int a, de;
    bit ok;
    logic [18:0] pc;
    clear_mon();
    exp_q.delete();
    exp_q.push_back(19'd1290); exp_q.push_back(19'd1291); exp_q.push_back(19'd1292);
    exp_q.push_back(19'd1930); exp_q.push_back(19'd1931); exp_q.push_back(19'd1932);
    send_cmd(1'b0, 2'b00, 10'd10, 10'd2, 10'd3, 10'd2, 8'h5A, a);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy got %b want 1", busy); end
    wait_done(1'b0, 50, de, ok);
    pc = pixel_count;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL fill_done_timeout got none want done"); end
    n_cmp++; if (de !== a + 8) begin n_fail++; $display("FAIL fill_done_edge got %0d want %0d", de, a + 8); end
    n_cmp++; if (pc !== 19'd6) begin n_fail++; $display("FAIL fill_pixel_count got %0d want 6", pc); end
    @(negedge Clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_after got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_busy_after got %b want 0", busy); end
    n_cmp++; if (m_addr_q.size() != exp_q.size()) begin n_fail++; $display("FAIL fill_write_count got %0d want %0d", m_addr_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < m_addr_q.size()) begin
        n_cmp++; if (m_addr_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fill_addr[%0d] got %0d want %0d", i, m_addr_q[i], exp_q[i]); end
        n_cmp++; if (m_data_q[i] !== 8'h5A) begin n_fail++; $display("FAIL fill_data[%0d] got %0h want 5a", i, m_data_q[i]); end
        n_cmp++; if (m_cyc_q[i] != a + 2 + i) begin n_fail++; $display("FAIL fill_cycle[%0d] got %0d want %0d", i, m_cyc_q[i], a + 2 + i); end
      end
    end
    n_cmp++; if (m_done_q.size() != 1) begin n_fail++; $display("FAIL fill_done_pulses got %0d want 1", m_done_q.size()); end
  endtask

  task automatic test_clip();
    int a, de;
    bit ok;
    logic [18:0] pc;
    int over;
    clear_mon();
    send_cmd(1'b0, 2'b00, 10'd638, 10'd479, 10'd5, 10'd4, 8'hFF, a);
    wait_done(1'b0, 50, de, ok);
    pc = pixel_count;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL clip_done_timeout got none want done"); end
    n_cmp++; if (de !== a + 4) begin n_fail++; $display("FAIL clip_done_edge got %0d want %0d", de, a + 4); end
    n_cmp++; if (pc !== 19'd2) begin n_fail++; $display("FAIL clip_pixel_count got %0d want 2", pc); end
    @(negedge Clk);
    n_cmp++; if (m_addr_q.size() != 2) begin n_fail++; $display("FAIL clip_write_count got %0d want 2", m_addr_q.size()); end
    if (m_addr_q.size() >= 2) begin
      n_cmp++; if (m_addr_q[0] !== 19'd307198) begin n_fail++; $display("FAIL clip_addr0 got %0d want 307198", m_addr_q[0]); end
      n_cmp++; if (m_addr_q[1] !== 19'd307199) begin n_fail++; $display("FAIL clip_addr1 got %0d want 307199", m_addr_q[1]); end
      n_cmp++; if (m_data_q[1] !== 8'hFF) begin n_fail++; $display("FAIL clip_data got %0h want ff", m_data_q[1]); end
    end
    over = 0;
    foreach (m_addr_q[i]) if (m_addr_q[i] > 19'd307199) over++;
    n_cmp++; if (over != 0) begin n_fail++; $display("FAIL clip_addr_range got %0d out-of-range want 0", over); end
  endtask

  task automatic test_empty();
    logic [1:0] ops[3];
    logic [9:0] xs[3], ws[3];
    int a, de;
    bit ok;
    logic [18:0] pc;
    ops[0] = 2'b00; xs[0] = 10'd5;   ws[0] = 10'd0;
    ops[1] = 2'b00; xs[1] = 10'd700; ws[1] = 10'd4;
    ops[2] = 2'b11; xs[2] = 10'd5;   ws[2] = 10'd4;
    for (int k = 0; k < 3; k++) begin
      clear_mon();
      send_cmd(1'b0, ops[k], xs[k], 10'd5, ws[k], 10'd4, 8'h33, a);
      wait_done(1'b0, 20, de, ok);
      pc = pixel_count;
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL empty%0d_done_timeout got none want done", k); end
      n_cmp++; if (de !== a + 2) begin n_fail++; $display("FAIL empty%0d_done_edge got %0d want %0d", k, de, a + 2); end
      n_cmp++; if (pc !== 19'd0) begin n_fail++; $display("FAIL empty%0d_pixel_count got %0d want 0", k, pc); end
      @(negedge Clk);
      n_cmp++; if (m_addr_q.size() != 0) begin n_fail++; $display("FAIL empty%0d_writes got %0d want 0", k, m_addr_q.size()); end
      n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL empty%0d_ready got %b want 1", k, cmd_ready); end
    end
  endtask

  task automatic test_clear_ignore();
    int a, de, bad;
    bit ok;
    logic [18:0] pc;
    clear_mon();
    send_cmd(1'b1, 2'b01, 10'd5, 10'd7, 10'd1, 10'd1, 8'h03, a);
    repeat (100) @(negedge Clk);
    s_cmd_op = 2'b00; s_cmd_x = 10'd0; s_cmd_y = 10'd0; s_cmd_w = 10'd1; s_cmd_h = 10'd1;
    s_cmd_color = 8'hEE;
    s_cmd_valid = 1'b1;
    @(negedge Clk);
    s_cmd_valid = 1'b0;
    wait_done(1'b1, 2000, de, ok);
    pc = s_pixel_count;
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL clear_done_timeout got none want done"); end
    n_cmp++; if (de !== a + 770) begin n_fail++; $display("FAIL clear_done_edge got %0d want %0d", de, a + 770); end
    n_cmp++; if (pc !== 19'd768) begin n_fail++; $display("FAIL clear_pixel_count got %0d want 768", pc); end
    repeat (10) @(negedge Clk);
    n_cmp++; if (s_addr_q.size() != 768) begin n_fail++; $display("FAIL clear_write_count got %0d want 768", s_addr_q.size()); end
    bad = 0;
    foreach (s_addr_q[i]) begin
      if (s_addr_q[i] !== 19'(i) || s_data_q[i] !== 8'h03 || s_cyc_q[i] != a + 2 + i) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL clear_sequence got %0d bad writes want 0", bad); end
    n_cmp++; if (s_done_q.size() != 1) begin n_fail++; $display("FAIL clear_done_pulses got %0d want 1", s_done_q.size()); end
    n_cmp++; if (s_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL clear_ready got %b want 1", s_cmd_ready); end
  endtask

  task automatic test_reset_mid();
    int a;
    clear_mon();
    send_cmd(1'b0, 2'b00, 10'd0, 10'd0, 10'd10, 10'd10, 8'h77, a);
    repeat (5) @(negedge Clk);
    n_cmp++; if (fb_wren !== 1'b1) begin n_fail++; $display("FAIL rmid_fourth_wren got %b want 1", fb_wren); end
    n_cmp++; if (fb_wraddress !== 19'd3) begin n_fail++; $display("FAIL rmid_fourth_addr got %0d want 3", fb_wraddress); end
    Reset = 1'b1;
    @(negedge Clk);
    n_cmp++; if (fb_wren !== 1'b0) begin n_fail++; $display("FAIL rmid_wren got %b want 0", fb_wren); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready got %b want 1", cmd_ready); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b want 0", done); end
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    n_cmp++; if (m_done_q.size() != 0) begin n_fail++; $display("FAIL rmid_done_pulses got %0d want 0", m_done_q.size()); end
    n_cmp++; if (m_addr_q.size() != 4) begin n_fail++; $display("FAIL rmid_write_count got %0d want 4", m_addr_q.size()); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rmid_state got %0d want 0", dbg_state); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    Reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    s_cmd_valid = 1'b0; s_cmd_op = '0; s_cmd_x = '0; s_cmd_y = '0; s_cmd_w = '0; s_cmd_h = '0;
    s_cmd_color = '0;
    test_reset();
    test_fill_basic();
    test_clip();
    test_empty();
    test_clear_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
Write-side engine for the 640x480, 8-bit-per-pixel dual-port frame buffer. The VGA path scans the read port; this block drives the write port (wraddress/data/wren).
- Accepts rectangle-fill and clear-screen commands from the software-facing command path through a valid/ready handshake.
- Clips each rectangle to the screen.
- Streams one pixel write per clock in raster order, then pulses done.

Parameters:
H_RES, 640, visible width in pixels
V_RES, 480, visible height in pixels
ADDR_W, 19, frame buffer address width
COLOR_W, 8, pixel colour width

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  00 fill rect, 01 clear screen, 10/11 reserved
cmd_x  in  10  rect left column
cmd_y  in  10  rect top row
cmd_w  in  10  rect width in pixels
cmd_h  in  10  rect height in pixels
cmd_color  in  COLOR_W  fill colour
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
pixel_count  out  ADDR_W  pixels written by the last completed command
fb_wraddress  out  ADDR_W  frame buffer write address
fb_data  out  COLOR_W  frame buffer write data
fb_wren  out  1  frame buffer write enable

Behaviour:
- Clock and reset: one clock domain (Clk). Reset is synchronous, active-high.
- Reset values: cmd_ready=1, busy=0, done=0, pixel_count=0, fb_wren=0, fb_wraddress=0, fb_data=0. State returns to IDLE.
- Output timing: all outputs are registered.
- FSM states: IDLE, SETUP, DRAW, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On the edge where cmd_valid=1, latch op/x/y/w/h/color and go to SETUP.
  - From the next cycle until DONE exits: cmd_ready=0, busy=1.
- Clear-screen op: 01 is treated as x=0, y=0, w=H_RES, h=V_RES. It ignores cmd_x/y/w/h and uses cmd_color.
- SETUP (exactly 1 cycle):
  - x_end=min(x+w, H_RES), y_end=min(y+h, V_RES), computed in 11-bit arithmetic so there is no overflow.
  - row_base=y*H_RES, computed as (y<<9)+(y<<7) for the default. No multiplier is required.
  - Empty command (w=0, h=0, x>=H_RES, y>=V_RES, or reserved op): go directly to DONE with zero writes.
  - Otherwise go to DRAW with cx=x, cy=y.
- DRAW, each cycle:
  - Outputs: fb_wren=1, fb_wraddress=row_base+cx, fb_data=latched colour. The write count increments.
  - Column advance: if cx==x_end-1, then cx<=x, cy<=cy+1, row_base<=row_base+H_RES; else cx<=cx+1.
  - After the write at (x_end-1, y_end-1), go to DONE. fb_wren is 0 in the following cycle.
- DONE (1 cycle):
  - done=1, pixel_count=write count, fb_wren=0.
  - Next state IDLE, with cmd_ready=1 and busy=0.
- Latency: the first fb_wren=1 appears 2 cycles after the accepting edge. done rises 1 cycle after the last write.
  - Non-empty command: total accept-to-ready = 2+N+1 cycles (N = pixels written).
  - Empty command: done 2 cycles after accept.
- Write ordering: raster order, left-to-right then top-to-bottom, with no gaps or duplicates.
  - fb_wraddress never exceeds H_RES*V_RES-1 = 307199.
- cmd_valid while busy: ignored, not queued. Latched parameters are unaffected by input changes during a command.
- Colour: cmd_color is written verbatim. There is no transparency key; value 0x00 is written like any other.
- Reset mid-command: the command is aborted. fb_wren=0 and done=0 from the cycle after Reset, and cmd_ready=1. Pixels already written remain in the buffer.
- Back-to-back commands: a new command may be accepted in the first IDLE cycle after DONE.
- pixel_count: holds its value until the next DONE. The maximum is 307200, which fits in ADDR_W.

Test Plan:
1. Reset asserted 3 cycles, then released -> cmd_ready=1, busy=0, done=0, fb_wren=0, fb_wraddress=0, pixel_count=0.
2. Fill x=10, y=2, w=3, h=2, color=0x5A:
   - writes to 1290, 1291, 1292, 1930, 1931, 1932, all with data 0x5A, on consecutive cycles starting 2 cycles after accept;
   - done pulses once 1 cycle after the last write; pixel_count=6; cmd_ready=1 on the next cycle.
3. Clipping, fill x=638, y=479, w=5, h=4, color=0xFF -> exactly 2 writes, at 307198 and 307199; pixel_count=2; no address >307199.
4. Empty commands (w=0; x=700; op=11) -> zero fb_wren cycles; done 2 cycles after accept; pixel_count=0 each time.
5. Clear screen with color=0x03, plus a second cmd_valid pulsed mid-draw:
   - 307200 consecutive writes at addresses 0..307199, all data 0x03;
   - the second command is ignored; pixel_count=307200; done pulses exactly once.
6. Reset asserted on the 4th write of a w=10, h=10 fill -> fb_wren=0 and cmd_ready=1 the next cycle; done is never asserted.
